serial_checking_sink: RTL and testbench

- Terminating endpoint for one router output channel.
- Receives serial flits, deserializes them and buffers them in a small FIFO, then consumes them at a fixed drain rate.
- Applies back-pressure on channel_busy and counts consumed flits and flits that arrived at the wrong node.
- Used as the self-checking counterpart to the memory-driven serial source in single-router and mesh benches.

---
 rtl/serial_checking_sink.sv | 228 ++++++++++++++++++++++
 tb/tb_serial_checking_sink.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_checking_sink.sv
// serial_checking_sink: terminating endpoint for one router output channel.
// Deserializes start-bit-framed flits from serial_in, buffers them in a small
// FIFO, consumes one flit every DRAIN_PERIOD cycles, and reports consumed and
// misrouted flit counts. Back-pressure on channel_busy keeps one FIFO slot free
// for a flit already in flight, and an LFSR "mood" can refuse traffic at random.
// Optional feature macro: SINK_DEST_CHECK_EN builds the destination comparator
// and the misroute counter; without it misroute_count is tied to 0.
module serial_checking_sink #(
   parameter int id           = 0,
   parameter int FLIT_W       = 8,
   parameter int DEST_W       = 4,
   parameter int DEPTH        = 4,
   parameter int DRAIN_PERIOD = 4,
   parameter int HOSPITALITY  = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   output logic              channel_busy,
   output logic              flit_valid,
   output logic [FLIT_W-1:0] flit_out,
   output logic [19:0]       flit_counter,
   output logic [15:0]       misroute_count,
   output logic              overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BIT_W = $clog2(FLIT_W);
   localparam int TMR_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

   localparam logic [6:0]       ID_LOW    = 7'(id);
   localparam logic [7:0]       LFSR_SEED = {ID_LOW, 1'b1};
   localparam logic [7:0]       HOSP_LIM  = 8'(HOSPITALITY);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FLIT_W - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DRAIN_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_HIGH  = CNT_W'(DEPTH - 1);

   // Reject configurations the pointer arithmetic and framing cannot support
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("serial_checking_sink: DEPTH must be a power of two, at least 2");
   end
   if (DRAIN_PERIOD < 1) begin : g_drain_check
      $error("serial_checking_sink: DRAIN_PERIOD must be at least 1");
   end
   if (DEST_W < 1 || DEST_W > FLIT_W || FLIT_W < 2) begin : g_width_check
      $error("serial_checking_sink: need FLIT_W >= 2 and 1 <= DEST_W <= FLIT_W");
   end
   if (HOSPITALITY < 0 || HOSPITALITY > 255) begin : g_hosp_check
      $error("serial_checking_sink: HOSPITALITY must be within 0..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [FLIT_W-1:0]   shreg_q, shreg_d;
   logic [FLIT_W-1:0]   fifo_mem_q [DEPTH];
   logic [FLIT_W-1:0]   fifo_mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [7:0]          lfsr_q, lfsr_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [FLIT_W-1:0]   flit_out_q, flit_out_d;
   logic [19:0]         counter_q, counter_d;
   logic                overflow_q, overflow_d;

   logic [FLIT_W-1:0]   head;
   logic                drain_wrap;
   logic                fifo_empty;
   logic                fifo_full;
   logic                pop;
   logic                push;
   logic                drop;
   logic                mood_refuse;

   // Next-state logic: receive FSM, FIFO bookkeeping, drain timer, LFSR mood
   // and the registered back-pressure and consume outputs.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      fifo_mem_d  = fifo_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      flit_out_d  = flit_out_q;
      counter_d   = counter_q;
      overflow_d  = overflow_q;
      valid_d     = 1'b0;

      lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      mood_refuse = (lfsr_q > HOSP_LIM);

      drain_wrap  = (timer_q == TMR_LAST);
      timer_d     = drain_wrap ? '0 : timer_q + TMR_W'(1);

      head        = fifo_mem_q[rd_ptr_q];
      fifo_empty  = (count_q == '0);
      fifo_full   = (count_q == CNT_FULL);
      pop         = drain_wrap && !fifo_empty;
      push        = (state_q == COMMIT) && (!fifo_full || pop);
      drop        = (state_q == COMMIT) && !push;

      case (state_q)
         IDLE: begin
            if (serial_in) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            shreg_d   = {shreg_q[FLIT_W-2:0], serial_in};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (push) begin
         fifo_mem_d[wr_ptr_q] = shreg_q;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         flit_out_d = head;
         valid_d    = 1'b1;
         counter_d  = counter_q + 20'd1;
      end

      if (drop) begin
         overflow_d = 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      busy_d = (count_d >= CNT_HIGH) | mood_refuse;
   end

   // State register with synchronous active-low reset; FIFO storage is not
   // cleared since the pointers and count already mark it empty.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         timer_q    <= '0;
         lfsr_q     <= LFSR_SEED;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         flit_out_q <= '0;
         counter_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         fifo_mem_q <= fifo_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         lfsr_q     <= lfsr_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         flit_out_q <= flit_out_d;
         counter_q  <= counter_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef SINK_DEST_CHECK_EN
   localparam logic [DEST_W-1:0] ID_DEST = DEST_W'(id);

   logic [15:0] misroute_q, misroute_d;

   // Count consumed flits addressed to another node, holding at the top value
   always_comb begin
      misroute_d = misroute_q;
      if (pop && (head[DEST_W-1:0] != ID_DEST) && (misroute_q != 16'hFFFF)) begin
         misroute_d = misroute_q + 16'd1;
      end
   end

   // Misroute counter register, cleared with the rest of the sink
   always_ff @(posedge clk) begin
      if (!reset) begin
         misroute_q <= '0;
      end else begin
         misroute_q <= misroute_d;
      end
   end

   assign misroute_count = misroute_q;
`else
   assign misroute_count = 16'd0;
`endif

   assign channel_busy = busy_q;
   assign flit_valid   = valid_q;
   assign flit_out     = flit_out_q;
   assign flit_counter = counter_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_serial_checking_sink.sv
// tb_serial_checking_sink: self-checking bench for serial_checking_sink.
// Instance A (DRAIN_PERIOD=4) takes table vectors and random traffic checked
// by a queue scoreboard; instance B (DRAIN_PERIOD=64) exercises back-pressure
// and overflow; instance M (HOSPITALITY=0) exercises the refusal mood.
module tb_serial_checking_sink;

`ifdef SINK_DEST_CHECK_EN
   localparam bit DEST_CHECK = 1'b1;
`else
   localparam bit DEST_CHECK = 1'b0;
`endif

   typedef struct {
      logic [7:0]  flit;
      logic [19:0] expCount;
      logic [15:0] expMisOn;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ser_a = 1'b0;
   logic ser_b = 1'b0;
   logic ser_m = 1'b0;

   logic        busy_a, valid_a, ovf_a;
   logic [7:0]  flit_a;
   logic [19:0] counter_a;
   logic [15:0] mis_a;
   logic        busy_b, valid_b, ovf_b;
   logic [7:0]  flit_b;
   logic [19:0] counter_b;
   logic [15:0] mis_b;
   logic        busy_m, valid_m, ovf_m;
   logic [7:0]  flit_m;
   logic [19:0] counter_m;
   logic [15:0] mis_m;

   int checks = 0;
   int failures = 0;

   logic [7:0]  sent_q [$];
   logic [19:0] model_count = '0;
   logic [15:0] model_mis = '0;

   // Free-running system clock
   always #5 clk = ~clk;

   serial_checking_sink #(.id(0), .DRAIN_PERIOD(4)) dut_a (
      .clk(clk), .reset(reset), .serial_in(ser_a), .channel_busy(busy_a),
      .flit_valid(valid_a), .flit_out(flit_a), .flit_counter(counter_a),
      .misroute_count(mis_a), .overflow(ovf_a));

   serial_checking_sink #(.id(0), .DRAIN_PERIOD(64)) dut_b (
      .clk(clk), .reset(reset), .serial_in(ser_b), .channel_busy(busy_b),
      .flit_valid(valid_b), .flit_out(flit_b), .flit_counter(counter_b),
      .misroute_count(mis_b), .overflow(ovf_b));

   serial_checking_sink #(.id(5), .HOSPITALITY(0)) dut_m (
      .clk(clk), .reset(reset), .serial_in(ser_m), .channel_busy(busy_m),
      .flit_valid(valid_m), .flit_out(flit_m), .flit_counter(counter_m),
      .misroute_count(mis_m), .overflow(ovf_m));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic laneBusy(input int lane);
      return (lane == 0) ? busy_a : busy_b;
   endfunction

   function automatic logic laneValid(input int lane);
      return (lane == 0) ? valid_a : valid_b;
   endfunction

   task automatic setLine(input int lane, input logic b);
      if (lane == 0) ser_a = b;
      else ser_b = b;
   endtask

   // Start bit, FLIT_W data bits MSB first, then one idle bit
   task automatic sendFlit(input int lane, input logic [7:0] data, input bit obey);
      int waited;
      waited = 0;
      @(negedge clk);
      while (obey && laneBusy(lane) && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 300) checkOutput("tx_wait_timeout", 32'(laneBusy(lane)), 0);
      setLine(lane, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         setLine(lane, data[i]);
      end
      @(negedge clk);
      setLine(lane, 1'b0);
      if (lane == 0) sent_q.push_back(data);
   endtask

   task automatic waitValid(input int lane, input int limit, input string name, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (laneValid(lane)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput(name, 0, 1);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      ser_a = 1'b0;
      ser_b = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One table vector: send it on lane A, then check the consume pulse
   task automatic applyStimulus(input vec_t v, input int idx);
      bit seen;
      sendFlit(0, v.flit, 1'b1);
      waitValid(0, 40, $sformatf("vec%0d_timeout", idx), seen);
      if (seen) begin
         checkOutput($sformatf("vec%0d_flit", idx), 32'(flit_a), 32'(v.flit));
         checkOutput($sformatf("vec%0d_count", idx), 32'(counter_a), 32'(v.expCount));
         checkOutput($sformatf("vec%0d_misroute", idx), 32'(mis_a),
                     32'(DEST_CHECK ? v.expMisOn : 16'd0));
         @(negedge clk);
         checkOutput($sformatf("vec%0d_pulse_len", idx), 32'(valid_a), 0);
         checkOutput($sformatf("vec%0d_hold", idx), 32'(flit_a), 32'(v.flit));
         checkOutput($sformatf("vec%0d_busy", idx), 32'(busy_a), 0);
      end
   endtask

   // Scoreboard for lane A: every consume must match the oldest sent flit
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (!reset) begin
            sent_q.delete();
            model_count = '0;
            model_mis = '0;
         end else if (valid_a) begin
            if (sent_q.size() == 0) begin
               checkOutput("sb_spurious_valid", 1, 0);
            end else begin
               exp = sent_q.pop_front();
               model_count = model_count + 20'd1;
               if (DEST_CHECK && exp[3:0] != 4'd0 && model_mis != 16'hFFFF)
                  model_mis = model_mis + 16'd1;
               checkOutput("sb_flit", 32'(flit_a), 32'(exp));
               checkOutput("sb_count", 32'(counter_a), 32'(model_count));
               checkOutput("sb_misroute", 32'(mis_a), 32'(model_mis));
            end
         end
      end
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t       vecs [5];
      logic [7:0] ovf_data [5];
      logic [7:0] d;
      int         rand_mis;
      bit         seen;
      bit         dropped;

      vecs[0] = '{flit: 8'hA0, expCount: 20'd1, expMisOn: 16'd0};
      vecs[1] = '{flit: 8'h53, expCount: 20'd2, expMisOn: 16'd1};
      vecs[2] = '{flit: 8'h10, expCount: 20'd3, expMisOn: 16'd1};
      vecs[3] = '{flit: 8'hFF, expCount: 20'd4, expMisOn: 16'd2};
      vecs[4] = '{flit: 8'h00, expCount: 20'd5, expMisOn: 16'd2};
      ovf_data = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};

      $display("[TB] power-on reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Partial flit interrupted by reset, with the line toggling during reset
      @(negedge clk);
      ser_a = 1'b1;
      repeat (4) begin
         @(negedge clk);
         ser_a = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ser_a = ~ser_a;
         ser_b = ~ser_b;
      end
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy_a), 0);
      checkOutput("rst_valid", 32'(valid_a), 0);
      checkOutput("rst_flit", 32'(flit_a), 0);
      checkOutput("rst_count", 32'(counter_a), 0);
      checkOutput("rst_misroute", 32'(mis_a), 0);
      checkOutput("rst_overflow", 32'(ovf_a), 0);
      checkOutput("rst_mood_busy", 32'(busy_m), 0);
      reset = 1'b1;
      ser_a = 1'b0;
      ser_b = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("mood_busy_after_release", 32'(busy_m), 1);

      $display("[TB] table vectors");
      for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

      $display("[TB] random traffic");
      rand_mis = 0;
      for (int n = 0; n < 40; n++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) d[3:0] = 4'd0;
         if (d[3:0] != 4'd0) rand_mis++;
         sendFlit(0, d, 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (60) @(negedge clk);
      checkOutput("rand_drained", 32'(sent_q.size()), 0);
      checkOutput("rand_total_count", 32'(counter_a), 45);
      checkOutput("rand_total_misroute", 32'(mis_a), DEST_CHECK ? 32'(2 + rand_mis) : 0);
      checkOutput("rand_no_overflow", 32'(ovf_a), 0);
      checkOutput("mood_busy_steady", 32'(busy_m), 1);

      $display("[TB] back-pressure");
      doReset();
      sendFlit(1, 8'h11, 1'b1);
      @(negedge clk);
      checkOutput("bp_busy_after1", 32'(busy_b), 0);
      sendFlit(1, 8'h22, 1'b1);
      @(negedge clk);
      checkOutput("bp_busy_after2", 32'(busy_b), 0);
      sendFlit(1, 8'h33, 1'b1);
      @(negedge clk);
      checkOutput("bp_busy_after3", 32'(busy_b), 1);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!busy_b) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("bp_busy_dropped", 32'(seen), 1);
      checkOutput("bp_drop_with_pop", 32'(valid_b), 1);
      checkOutput("bp_drop_count", 32'(counter_b), 1);
      checkOutput("bp_drop_flit", 32'(flit_b), 32'h11);

      $display("[TB] overflow");
      doReset();
      for (int i = 0; i < 5; i++) begin
         sendFlit(1, ovf_data[i], 1'b0);
         @(negedge clk);
         if (i == 3) begin
            checkOutput("ovf_clear_at_full", 32'(ovf_b), 0);
            checkOutput("ovf_busy_at_full", 32'(busy_b), 1);
         end
      end
      checkOutput("ovf_set", 32'(ovf_b), 1);
      for (int i = 0; i < 4; i++) begin
         waitValid(1, 80, $sformatf("ovf_pop%0d_timeout", i), seen);
         if (seen) checkOutput($sformatf("ovf_order%0d", i), 32'(flit_b), 32'(ovf_data[i]));
      end
      dropped = 1'b1;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (valid_b) dropped = 1'b0;
      end
      checkOutput("ovf_fifth_dropped", 32'(dropped), 1);
      checkOutput("ovf_count", 32'(counter_b), 4);
      checkOutput("ovf_misroute", 32'(mis_b), DEST_CHECK ? 4 : 0);
      checkOutput("ovf_sticky", 32'(ovf_b), 1);
      checkOutput("ovf_busy_released", 32'(busy_b), 0);

      checkOutput("mood_busy_final", 32'(busy_m), 1);
      checkOutput("mood_no_valid", 32'(valid_m), 0);
      checkOutput("mood_no_count", 32'(counter_m), 0);
      checkOutput("mood_no_flit", 32'(flit_m), 0);
      checkOutput("mood_no_misroute", 32'(mis_m), 0);
      checkOutput("mood_no_overflow", 32'(ovf_m), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
